// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge bus between the MEM-stage access unit and data memory.
interface mem_access_if;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_be, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory unit; stalls the pipeline during req/ack and returns aligned, extended loads.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses on adel/ades/bad_vaddr.
module mem_access (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [31:0]         mem_alu_result,
  input  logic [31:0]         mem_busB,
  input  logic [1:0]          mem_MemWr,
  input  logic [1:0]          mem_MemRead,
  input  logic                mem_LoadUnsigned,
  mem_access_if.master        dm,
  output logic                stall,
  output logic [31:0]         load_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                adel,
  output logic                ades,
  output logic [31:0]         bad_vaddr
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_lsize;
  logic [1:0]  r_lo;
  logic        r_unsigned;
  logic        w_access;
  logic        w_store;
  logic        w_mis;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  assign w_store  = |mem_MemWr;
  assign w_access = w_store | (|mem_MemRead);
  assign w_size   = w_store ? mem_MemWr : mem_MemRead;
  assign w_be     = w_size == 2'd1 ? 4'b0001 << mem_alu_result[1:0] :
                    w_size == 2'd2 ? 4'b0011 << {mem_alu_result[1], 1'b0} : 4'b1111;
  assign w_wdata  = mem_MemWr == 2'd1 ? {4{mem_busB[7:0]}} :
                    mem_MemWr == 2'd2 ? {2{mem_busB[15:0]}} : mem_busB;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis    = (w_size == 2'd2 & mem_alu_result[0]) | (w_size == 2'd3 & |mem_alu_result[1:0]);
`else
  assign w_mis    = 1'b0;
`endif
  assign stall    = (r_state == IDLE & w_access) | r_state == BUSY;

  // r_lsize is 0 for stores, so a store (even one with a load field set) returns 0
  assign w_shift  = r_lsize == 2'd1 ? dm.dm_rdata >> {r_lo, 3'b000} :
                    r_lsize == 2'd2 ? dm.dm_rdata >> {r_lo[1], 4'b0000} : dm.dm_rdata;
  assign w_load   = r_lsize == 2'd1 ? {{24{~r_unsigned & w_shift[7]}}, w_shift[7:0]} :
                    r_lsize == 2'd2 ? {{16{~r_unsigned & w_shift[15]}}, w_shift[15:0]} :
                    r_lsize == 2'd3 ? w_shift : 32'd0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_lsize     <= 2'd0;
      r_lo        <= 2'd0;
      r_unsigned  <= 1'b0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= 30'd0;
      dm.dm_be    <= 4'd0;
      dm.dm_wdata <= 32'd0;
      load_data   <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      adel        <= 1'b0;
      ades        <= 1'b0;
      bad_vaddr   <= 32'd0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      adel <= 1'b0;
      ades <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_access) begin
          r_lsize    <= w_store ? 2'd0 : mem_MemRead;
          r_lo       <= mem_alu_result[1:0];
          r_unsigned <= mem_LoadUnsigned;
          if (w_mis) begin
            r_state <= DONE;
`ifdef MEM_ALIGN_CHECK_EN
            adel      <= ~w_store;
            ades      <= w_store;
            bad_vaddr <= mem_alu_result;
`endif
          end else begin
            r_state     <= BUSY;
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= w_store;
            dm.dm_addr  <= mem_alu_result[31:2];
            dm.dm_be    <= w_be;
            dm.dm_wdata <= w_wdata;
          end
        end
        BUSY: if (dm.dm_ack) begin
          dm.dm_req <= 1'b0;
          load_data <= w_load;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven directed vectors plus hand sequences for idle ack, async reset and alignment.
module tb_mem_access;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_busB = '0;
  logic [1:0]  mem_MemWr = '0;
  logic [1:0]  mem_MemRead = '0;
  logic        mem_LoadUnsigned = 1'b0;
  logic        stall;
  logic [31:0] load_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        adel, ades;
  logic [31:0] bad_vaddr;
`endif
  int n_chk = 0;
  int n_fail = 0;

  mem_access_if dm();

  mem_access dut (
    .Clk(Clk), .Rst_n(Rst_n), .mem_alu_result(mem_alu_result), .mem_busB(mem_busB),
    .mem_MemWr(mem_MemWr), .mem_MemRead(mem_MemRead), .mem_LoadUnsigned(mem_LoadUnsigned),
    .dm(dm), .stall(stall), .load_data(load_data)
`ifdef MEM_ALIGN_CHECK_EN
    , .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] busb;
    logic [31:0] rdata;
    int          waits;
    logic        we;
    logic [29:0] eaddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  vec_t v[10];
  vec_t m[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t x, input string tag);
    int st;
    @(negedge Clk);
    mem_MemWr = x.wr; mem_MemRead = x.rd; mem_LoadUnsigned = x.uns;
    mem_alu_result = x.addr; mem_busB = x.busb;
    dm.dm_rdata = x.rdata; dm.dm_ack = 1'b0;
    #1 st = int'(stall);
    chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
    @(negedge Clk);
    for (int i = 0; i <= x.waits; i++) begin
      if (i > 0) @(negedge Clk);
      st += int'(stall);
      chk({tag, ".req"}, 32'(dm.dm_req), 32'd1);
      chk({tag, ".we"}, 32'(dm.dm_we), 32'(x.we));
      chk({tag, ".addr"}, 32'(dm.dm_addr), 32'(x.eaddr));
      chk({tag, ".be"}, 32'(dm.dm_be), 32'(x.be));
      chk({tag, ".wdata"}, dm.dm_wdata, x.wdata);
    end
    dm.dm_ack = 1'b1;
    @(negedge Clk);
    dm.dm_ack = 1'b0;
    st += int'(stall);
    mem_MemWr = 2'd0; mem_MemRead = 2'd0;
    chk({tag, ".req_done"}, 32'(dm.dm_req), 32'd0);
    chk({tag, ".load"}, load_data, x.load);
    chk({tag, ".stall_cycles"}, 32'(st), 32'(x.waits + 2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    rd    uns   addr           busb           rdata          w  we    eaddr       be       wdata          load
    v[0] = '{2'd0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 30'h40, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    v[1] = '{2'd0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,         32'h8011_2233, 0, 1'b0, 30'h40, 4'b1000, 32'h0,         32'hFFFF_FF80};
    v[2] = '{2'd0, 2'd1, 1'b1, 32'h0000_0103, 32'h0,         32'h8011_2233, 1, 1'b0, 30'h40, 4'b1000, 32'h0,         32'h0000_0080};
    v[3] = '{2'd2, 2'd0, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'h0,         0, 1'b1, 30'h01, 4'b1100, 32'hABCD_ABCD, 32'h0};
    v[4] = '{2'd0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         32'h8011_2233, 3, 1'b0, 30'h40, 4'b1100, 32'h0,         32'hFFFF_8011};
    v[5] = '{2'd0, 2'd2, 1'b1, 32'h0000_0100, 32'h0,         32'h8011_2233, 0, 1'b0, 30'h40, 4'b0011, 32'h0,         32'h0000_2233};
    v[6] = '{2'd1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'h0,         2, 1'b1, 30'h40, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    v[7] = '{2'd3, 2'd0, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         0, 1'b1, 30'h04, 4'b1111, 32'hCAFE_F00D, 32'h0};
    v[8] = '{2'd3, 2'd3, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0055, 1, 1'b1, 30'h08, 4'b1111, 32'h1122_3344, 32'h0};
    v[9] = '{2'd0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 1'b0, 30'h40, 4'b0010, 32'h0,         32'h0000_007F};
    m[0] = '{2'd0, 2'd3, 1'b0, 32'h0000_0102, 32'h0,         32'h1234_5678, 0, 1'b0, 30'h40, 4'b1111, 32'h0,         32'h1234_5678};
    m[1] = '{2'd0, 2'd2, 1'b0, 32'h0000_0103, 32'h0,         32'hAABB_CCDD, 0, 1'b0, 30'h40, 4'b1100, 32'h0,         32'hFFFF_AABB};
    dm.dm_ack = 1'b0;
    dm.dm_rdata = '0;
    #12;
    chk("rst.req", 32'(dm.dm_req), 32'd0);
    chk("rst.we", 32'(dm.dm_we), 32'd0);
    chk("rst.addr", 32'(dm.dm_addr), 32'd0);
    chk("rst.be", 32'(dm.dm_be), 32'd0);
    chk("rst.wdata", dm.dm_wdata, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.load", load_data, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst.adel", 32'(adel), 32'd0);
    chk("rst.ades", 32'(ades), 32'd0);
    chk("rst.bad_vaddr", bad_vaddr, 32'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run(v[i], $sformatf("vec%0d", i));

    // ack while idle must be ignored
    @(negedge Clk);
    dm.dm_rdata = 32'hFFFF_FFFF; dm.dm_ack = 1'b1;
    @(negedge Clk);
    dm.dm_ack = 1'b0;
    chk("idle_ack.req", 32'(dm.dm_req), 32'd0);
    chk("idle_ack.load", load_data, 32'h0000_007F);
    chk("idle_ack.stall", 32'(stall), 32'd0);

    // async reset while BUSY, then a stray ack
    @(negedge Clk);
    mem_MemRead = 2'd3; mem_alu_result = 32'h0000_0200;
    @(negedge Clk);
    chk("rstbusy.req_before", 32'(dm.dm_req), 32'd1);
    #2 Rst_n = 1'b0; mem_MemRead = 2'd0;
    #1;
    chk("rstbusy.req", 32'(dm.dm_req), 32'd0);
    chk("rstbusy.addr", 32'(dm.dm_addr), 32'd0);
    chk("rstbusy.be", 32'(dm.dm_be), 32'd0);
    chk("rstbusy.load", load_data, 32'd0);
    chk("rstbusy.stall", 32'(stall), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    dm.dm_rdata = 32'h1234_5678; dm.dm_ack = 1'b1;
    @(negedge Clk);
    dm.dm_ack = 1'b0;
    chk("stray_ack.req", 32'(dm.dm_req), 32'd0);
    chk("stray_ack.load", load_data, 32'd0);
    chk("stray_ack.stall", 32'(stall), 32'd0);
    run(v[0], "after_rst");

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge Clk);
    mem_MemRead = 2'd3; mem_alu_result = 32'h0000_0102;
    #1 chk("adel.stall_idle", 32'(stall), 32'd1);
    @(negedge Clk);
    mem_MemRead = 2'd0;
    chk("adel.req", 32'(dm.dm_req), 32'd0);
    chk("adel.adel", 32'(adel), 32'd1);
    chk("adel.ades", 32'(ades), 32'd0);
    chk("adel.bad_vaddr", bad_vaddr, 32'h0000_0102);
    chk("adel.stall_done", 32'(stall), 32'd0);
    chk("adel.load", load_data, 32'hDEAD_BEEF);
    @(negedge Clk);
    chk("adel.pulse_end", 32'(adel), 32'd0);
    mem_MemWr = 2'd2; mem_alu_result = 32'h0000_0105;
    @(negedge Clk);
    mem_MemWr = 2'd0;
    chk("ades.req", 32'(dm.dm_req), 32'd0);
    chk("ades.ades", 32'(ades), 32'd1);
    chk("ades.adel", 32'(adel), 32'd0);
    chk("ades.bad_vaddr", bad_vaddr, 32'h0000_0105);
    @(negedge Clk);
    chk("ades.pulse_end", 32'(ades), 32'd0);
`else
    run(m[0], "mis_word");
    run(m[1], "mis_half");
`endif
    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
